// File: rtl/servo_pwm_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | servo_pwm_if : angle command in, servo pulse and status out          |
// | Revision     : 1.0                                                    |
// +----------------------------------------------------------------------+
interface servo_pwm_if;
  logic [9:0] angle;
  logic       en;
  logic       pwm;
  logic [7:0] cur_angle;
  logic       settled;

  modport master (output angle, en, input pwm, cur_angle, settled);
  modport slave  (input angle, en, output pwm, cur_angle, settled);
endinterface
`default_nettype wire

// File: rtl/servo_pwm.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | servo_pwm : slew-limited angle command to hobby-servo PWM frame      |
// | Revision  : 1.0                                                       |
// +----------------------------------------------------------------------+
module servo_pwm #(
  parameter int PERIOD_CYCLES = 960000,
  parameter int MIN_PULSE     = 48000,
  parameter int TICKS_PER_DEG = 266,
  parameter int SLEW_DEG      = 6,
  parameter int RESET_ANGLE   = 180
) (
  input  wire logic  clk,
  input  wire logic  reset,
  servo_pwm_if.slave bus
);

  localparam logic [0:0]  c_ST_PULSE    = 1'b0;
  localparam logic [0:0]  c_ST_GAP      = 1'b1;
  localparam logic [19:0] c_PERIOD_M1   = 20'(PERIOD_CYCLES - 1);
  localparam logic [19:0] c_MIN_PULSE   = 20'(MIN_PULSE);
  localparam logic [19:0] c_TICKS       = 20'(TICKS_PER_DEG);
  localparam logic [7:0]  c_MAX_ANGLE   = 8'd180;
  localparam logic [7:0]  c_RESET_ANGLE = 8'(RESET_ANGLE);
  localparam logic [19:0] c_RESET_PW    = 20'(MIN_PULSE + RESET_ANGLE * TICKS_PER_DEG);
  // Any slew of a full sweep or more degenerates to an immediate jump.
  localparam logic [7:0]  c_SLEW        = 8'((SLEW_DEG > 180) ? 180 : SLEW_DEG);

  logic [19:0] r_count;
  logic [7:0]  r_cur;
  logic        r_en;
  logic        r_settled;
  logic [19:0] r_pw;
  logic [0:0]  r_state;
  logic        r_pwm;

  logic        w_wrap;
  logic [7:0]  w_target_next;
  logic [7:0]  w_cur_next;
  logic [19:0] w_pw_next;
  logic [0:0]  w_state_next;
  logic        w_pwm_next;

  assign w_wrap        = (r_count == c_PERIOD_M1);
  assign w_target_next = (bus.angle > 10'd180) ? c_MAX_ANGLE : bus.angle[7:0];
  assign w_pw_next     = c_MIN_PULSE + 20'(w_cur_next) * c_TICKS;

  // Subtractions are ordered so they never wrap; stepping only happens when
  // the gap exceeds the slew, so cur +/- slew stays strictly inside 0..180.
  always_comb begin
    w_cur_next = w_target_next;
    if (w_target_next > r_cur) begin
      if ((w_target_next - r_cur) > c_SLEW) begin
        w_cur_next = r_cur + c_SLEW;
      end
    end else if ((r_cur - w_target_next) > c_SLEW) begin
      w_cur_next = r_cur - c_SLEW;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count   <= 20'd0;
      r_cur     <= c_RESET_ANGLE;
      r_en      <= 1'b1;
      r_settled <= 1'b1;
      r_pw      <= c_RESET_PW;
    end else if (w_wrap) begin
      r_count   <= 20'd0;
      r_cur     <= w_cur_next;
      r_en      <= bus.en;
      r_settled <= (w_cur_next == w_target_next);
      r_pw      <= w_pw_next;
    end else begin
      r_count   <= r_count + 20'd1;
    end
  end

  // State tracks "counter < pulse_width && en latched" for the current count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= c_ST_PULSE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (w_wrap) begin
      w_state_next = bus.en ? c_ST_PULSE : c_ST_GAP;
    end else if ((r_state == c_ST_PULSE) && ((r_count + 20'd1) >= r_pw)) begin
      w_state_next = c_ST_GAP;
    end
  end

  always_comb begin
    w_pwm_next = (r_state == c_ST_PULSE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pwm <= 1'b0;
    end else begin
      r_pwm <= w_pwm_next;
    end
  end

  assign bus.pwm       = r_pwm;
  assign bus.cur_angle = r_cur;
  assign bus.settled   = r_settled;

endmodule
`default_nettype wire
